clint_timer_ctrl: RTL and testbench

Memory-mapped machine timer and software-interrupt controller for the RV64 core. It owns the architectural mtime, mtimecmp and msip registers and serves the core's MMIO load/store port through a valid/ready request/response handshake. It generates the level timer and software interrupt lines consumed by the trap/interrupt logic (timer_int_i path) and the CSR mip pending bits.

---
 rtl/clint_timer_ctrl.sv | 135 +++++++++++++
 tb/tb_clint_timer_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_ctrl.sv
// Machine timer / software-interrupt controller: owns mtime, mtimecmp and msip
// and serves them over a single-outstanding valid/ready MMIO request/response port.
module clint_timer_ctrl #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned DIV_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_en_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [7:0]  req_wstrb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        timer_int_o,
    output logic        soft_int_o,
    output logic [63:0] mtime_o
);

    localparam logic [63:0]      MSIP_ADDR     = BASE_ADDR + 64'h0000;
    localparam logic [63:0]      MTIMECMP_ADDR = BASE_ADDR + 64'h4000;
    localparam logic [63:0]      MTIME_ADDR    = BASE_ADDR + 64'hBFF8;
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] prescaler;
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic             timer_int;

    logic             accept;
    logic             sel_msip;
    logic             sel_mtimecmp;
    logic             sel_mtime;
    logic             addr_err;
    logic             wr_ok;
    logic             tick;
    logic [63:0]      mtime_inc;
    logic [63:0]      mtime_next;
    logic [63:0]      mtimecmp_next;
    logic             msip_next;
    logic [63:0]      read_data;

    // Next-state values for the architectural registers; writes override the
    // tick-incremented mtime only in the byte lanes that are strobed.
    always_comb begin
        accept       = req_valid_i && (state == IDLE);
        sel_msip     = (req_addr_i == MSIP_ADDR);
        sel_mtimecmp = (req_addr_i == MTIMECMP_ADDR);
        sel_mtime    = (req_addr_i == MTIME_ADDR);
        addr_err     = !(sel_msip || sel_mtimecmp || sel_mtime) || (req_addr_i[2:0] != 3'b000);
        wr_ok        = accept && req_wen_i && !addr_err;
        tick         = cnt_en_i && (prescaler == DIV_LAST);
        mtime_inc    = mtime + 64'(tick);

        mtime_next    = mtime_inc;
        mtimecmp_next = mtimecmp;
        for (int b = 0; b < 8; b++) begin
            if (wr_ok && sel_mtime && req_wstrb_i[b])
                mtime_next[8*b +: 8] = req_wdata_i[8*b +: 8];
            if (wr_ok && sel_mtimecmp && req_wstrb_i[b])
                mtimecmp_next[8*b +: 8] = req_wdata_i[8*b +: 8];
        end
        msip_next = (wr_ok && sel_msip && req_wstrb_i[0]) ? req_wdata_i[0] : msip;

        read_data = 64'h0;
        if (!req_wen_i && !addr_err) begin
            if (sel_msip)
                read_data = {63'h0, msip};
            else if (sel_mtimecmp)
                read_data = mtimecmp;
            else
                read_data = mtime;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= '0;
            mtime     <= 64'h0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip      <= 1'b0;
            rsp_rdata <= 64'h0;
            rsp_err   <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            if (cnt_en_i)
                prescaler <= tick ? '0 : prescaler + DIV_W'(1);
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            msip      <= msip_next;
            // Compare post-update values so the level tracks register writes immediately.
            timer_int <= (mtime_next >= mtimecmp_next);

            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_rdata <= read_data;
                        rsp_err   <= addr_err;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rsp_rdata;
    assign rsp_err_o   = rsp_err;
    assign timer_int_o = timer_int;
    assign soft_int_o  = msip;
    assign mtime_o     = mtime;

endmodule

// File: tb/tb_clint_timer_ctrl.sv
// Directed bench for clint_timer_ctrl: a register-access vector table plus
// hand-written sequences for timer compare, wrap, stall and prescaler cases.
module tb_clint_timer_ctrl;

    localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP = BASE + 64'h0000;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_en;
    logic        req_valid;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_err, timer_int, soft_int;
    logic [63:0] rsp_rdata, mtime;
    logic        req_ready4, rsp_valid4, rsp_err4, timer_int4, soft_int4;
    logic [63:0] rsp_rdata4, mtime4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_timer_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_en_i(cnt_en),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .timer_int_o(timer_int), .soft_int_o(soft_int),
        .mtime_o(mtime)
    );

    clint_timer_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(4), .DIV_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .cnt_en_i(cnt_en),
        .req_valid_i(req_valid), .req_ready_o(req_ready4), .req_wen_i(req_wen),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata4),
        .rsp_err_o(rsp_err4), .timer_int_o(timer_int4), .soft_int_o(soft_int4),
        .mtime_o(mtime4)
    );

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] expRdata;
        logic        expErr;
        logic        expSoft;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One full request/response transaction, consumed immediately.
    task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] wstrb, output logic [63:0] rdata,
                                 output logic err, output logic tmrAtRsp);
        checkOutput("req_ready before request", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        nextCycle();
        req_valid = 1'b0;
        checkOutput("rsp_valid one cycle after accept", 64'(rsp_valid), 64'd1);
        rdata     = rsp_rdata;
        err       = rsp_err;
        tmrAtRsp  = timer_int;
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        checkOutput("rsp_valid after consume", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic        tm;
        logic        found;

        vecs[0]  = '{1'b0, A_CMP,          64'h0,  8'h00, ONES,  1'b0, 1'b0, "rd mtimecmp reset"};
        vecs[1]  = '{1'b1, A_MSIP,         ONES,   8'hFF, 64'h0, 1'b0, 1'b1, "wr msip ones"};
        vecs[2]  = '{1'b0, A_MSIP,         64'h0,  8'h00, 64'h1, 1'b0, 1'b1, "rd msip set"};
        vecs[3]  = '{1'b1, A_MSIP,         64'h0,  8'h00, 64'h0, 1'b0, 1'b1, "wr msip wstrb0 noop"};
        vecs[4]  = '{1'b0, A_MSIP,         64'h0,  8'h00, 64'h1, 1'b0, 1'b1, "rd msip after noop"};
        vecs[5]  = '{1'b1, A_MSIP,         64'h0,  8'hFF, 64'h0, 1'b0, 1'b0, "wr msip zero"};
        vecs[6]  = '{1'b0, BASE + 64'h8,   64'h0,  8'h00, 64'h0, 1'b1, 1'b0, "rd offset 0x8 err"};
        vecs[7]  = '{1'b1, BASE + 64'h4004, 64'h0, 8'hFF, 64'h0, 1'b1, 1'b0, "wr 0x4004 err"};
        vecs[8]  = '{1'b1, A_CMP,          64'h0,  8'h00, 64'h0, 1'b0, 1'b0, "wr mtimecmp wstrb0"};
        vecs[9]  = '{1'b0, A_CMP,          64'h0,  8'h00, ONES,  1'b0, 1'b0, "rd mtimecmp unchanged"};
        vecs[10] = '{1'b1, BASE + 64'h3,   ONES,   8'hFF, 64'h0, 1'b1, 1'b0, "wr misaligned msip err"};
        vecs[11] = '{1'b0, A_MSIP,         64'h0,  8'h00, 64'h0, 1'b0, 1'b0, "rd msip still zero"};

        rst_n = 1'b0; cnt_en = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
        req_addr = 64'h0; req_wdata = 64'h0; req_wstrb = 8'h0; rsp_ready = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;

        checkOutput("reset mtime", mtime, 64'h0);
        checkOutput("reset timer_int", 64'(timer_int), 64'd0);
        checkOutput("reset soft_int", 64'(soft_int), 64'd0);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 64'h0);
        checkOutput("reset rsp_err", 64'(rsp_err), 64'd0);
        repeat (10) nextCycle();
        checkOutput("mtime after 10 cycles", mtime, 64'd10);
        checkOutput("timer_int after 10 cycles", 64'(timer_int), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, tm);
            checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].expRdata);
            checkOutput({vecs[i].name, " err"}, 64'(er), 64'(vecs[i].expErr));
            checkOutput({vecs[i].name, " soft_int"}, 64'(soft_int), 64'(vecs[i].expSoft));
        end

        // Timer compare rise and fall.
        applyStimulus(1'b1, A_TIME, 64'h0, 8'hFF, rd, er, tm);
        applyStimulus(1'b1, A_CMP, 64'd20, 8'hFF, rd, er, tm);
        checkOutput("timer_int low after cmp=20", 64'(tm), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (timer_int) found = 1'b1;
            else nextCycle();
        end
        checkOutput("timer_int rise seen", 64'(found), 64'd1);
        checkOutput("mtime at timer rise", mtime, 64'd20);
        applyStimulus(1'b1, A_CMP, 64'h100, 8'hFF, rd, er, tm);
        checkOutput("timer_int falls after cmp=0x100", 64'(tm), 64'd0);

        // Wrap of mtime past all-ones.
        applyStimulus(1'b1, A_CMP, ONES, 8'hFF, rd, er, tm);
        applyStimulus(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, tm);
        checkOutput("timer_int low at mtime=FE", 64'(tm), 64'd0);
        checkOutput("mtime at all-ones", mtime, ONES);
        checkOutput("timer_int at all-ones", 64'(timer_int), 64'd1);
        nextCycle();
        checkOutput("mtime after wrap", mtime, 64'h0);
        checkOutput("timer_int after wrap", 64'(timer_int), 64'd0);

        // Error response held while rsp_ready is low; a queued write must not be taken.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'h8;
        nextCycle();
        req_wen = 1'b1; req_addr = A_MSIP; req_wdata = 64'h1; req_wstrb = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("stall req_ready", 64'(req_ready), 64'd0);
            checkOutput("stall rsp_err", 64'(rsp_err), 64'd1);
            checkOutput("stall rsp_rdata", rsp_rdata, 64'h0);
            checkOutput("stall soft_int", 64'(soft_int), 64'd0);
            nextCycle();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        checkOutput("stall released rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("stalled write not taken", 64'(soft_int), 64'd0);

        // Prescaler with TICK_DIV=4 and a count-enable gap.
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        checkOutput("div4 reset mtime", mtime4, 64'h0);
        nextCycle();
        nextCycle();
        cnt_en = 1'b0;
        repeat (3) nextCycle();
        checkOutput("div4 frozen mtime", mtime4, 64'h0);
        checkOutput("div1 frozen mtime", mtime, 64'd2);
        cnt_en = 1'b1;
        nextCycle();
        checkOutput("div4 mtime before 4th enabled", mtime4, 64'h0);
        nextCycle();
        checkOutput("div4 first tick", mtime4, 64'd1);
        repeat (4) nextCycle();
        checkOutput("div4 second tick", mtime4, 64'd2);

        applyStimulus(1'b1, A_TIME, 64'h0000_0000_FFFF_FFFF, 8'hFF, rd, er, tm);
        nextCycle();
        checkOutput("div4 mtime before partial", mtime4, 64'h0000_0000_FFFF_FFFF);
        applyStimulus(1'b1, A_TIME, 64'hDEAD_BEEF_5555_5555, 8'h0F, rd, er, tm);
        checkOutput("div4 partial write with tick", mtime4, 64'h0000_0001_5555_5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
